// File: rtl/downcounter.sv
// Watchdog reset generator: fires a fixed-length reset pulse after
// RST_LMT consecutive WDFAIL-high edges. Optional WDFAIL_SYNC_EN macro.
module downcounter #(
   parameter int CNT_W         = 8,
   parameter int RST_PULSE_LEN = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             WDFAIL,
   input  logic [CNT_W-1:0] RST_LMT,
   output logic             RSTOUT
);

   localparam int PW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
   localparam logic [PW-1:0]    PLOAD = PW'(RST_PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      FIRE,
      HOLDOFF
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic             rstout_q, rstout_d;
   logic [CNT_W-1:0] lim;
   logic             wd;

`ifdef WDFAIL_SYNC_EN
   logic sync1_q, sync2_q;

   // Two-flop synchronizer for the asynchronous watchdog input
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= WDFAIL;
         sync2_q <= sync1_q;
      end
   end

   assign wd = sync2_q;
`else
   assign wd = WDFAIL;
`endif

   // Limit of zero is treated as one so the pulse still needs a high sample
   assign lim = (RST_LMT == '0) ? ONE : RST_LMT;

   // Next-state, counter and pulse-length logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      unique case (state_q)
         IDLE: begin
            if (wd) begin
               cnt_d = lim - ONE;
               if (lim == ONE) begin
                  state_d = FIRE;
                  pcnt_d  = PLOAD;
               end else begin
                  state_d = COUNT;
               end
            end
         end
         COUNT: begin
            if (!wd) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
               if (cnt_q == ONE) begin
                  state_d = FIRE;
                  pcnt_d  = PLOAD;
               end
            end
         end
         FIRE: begin
            if (pcnt_q == '0) begin
               state_d = HOLDOFF;
            end else begin
               pcnt_d = pcnt_q - 1'b1;
            end
         end
         HOLDOFF: begin
            if (!wd) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      rstout_d = (state_d == FIRE);
   end

   // State, counters and the glitch-free reset output flop
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pcnt_q   <= '0;
         rstout_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pcnt_q   <= pcnt_d;
         rstout_q <= rstout_d;
      end
   end

   assign RSTOUT = rstout_q;

endmodule

// File: tb/tb_downcounter.sv
// Directed testbench for the watchdog reset generator.
// Inputs change 1 ns after a rising edge; RSTOUT is checked there too.
module tb_downcounter;

   logic       CLK;
   logic       RST_N;
   logic       WDFAIL;
   logic [7:0] RST_LMT;
   logic       RSTOUT;

   int checks;
   int errors;

   downcounter #(
      .CNT_W(8),
      .RST_PULSE_LEN(4)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .WDFAIL(WDFAIL),
      .RST_LMT(RST_LMT),
      .RSTOUT(RSTOUT)
   );

   initial CLK = 1'b0;
   always #10 CLK = ~CLK;

   task automatic chk(input logic exp, input string tag);
      checks++;
      assert (RSTOUT === exp) else begin
         errors++;
         $error("FAIL %s: RSTOUT=%b expected %b", tag, RSTOUT, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // n edges, RSTOUT checked after each
   task automatic run(input int n, input logic exp, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(exp, tag);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      RST_N   = 1'b0;
      WDFAIL  = 1'b1;
      RST_LMT = 8'h0A;
      #1;
      chk(1'b0, "reset_t0");
      // 1: held in reset with WDFAIL high
      run(12, 1'b0, "reset_hold");
      WDFAIL = 1'b0;
      RST_N  = 1'b1;
      run(2, 1'b0, "reset_release");

      // 2: 8 high edges then low, never fires
      WDFAIL = 1'b1;
      run(8, 1'b0, "short_8");
      WDFAIL = 1'b0;
      run(2, 1'b0, "short_drop");

      // 3: long failure fires once on edge 10, 4 cycles, no retrigger
      WDFAIL = 1'b1;
      run(9, 1'b0, "long_pre");
      run(1, 1'b1, "long_rise10");
      run(3, 1'b1, "long_pulse");
      run(1, 1'b0, "long_fall");
      run(10, 1'b0, "long_no_retrig");
      WDFAIL = 1'b0;
      run(1, 1'b0, "long_holdoff_exit");

      // 4: dropout at edge 6 restarts the count
      WDFAIL = 1'b1;
      run(5, 1'b0, "restart_pre");
      WDFAIL = 1'b0;
      run(1, 1'b0, "restart_drop");
      WDFAIL = 1'b1;
      run(9, 1'b0, "restart_count");
      run(1, 1'b1, "restart_rise");
      WDFAIL = 1'b0;
      run(3, 1'b1, "restart_pulse");
      run(1, 1'b0, "restart_fall");
      run(1, 1'b0, "restart_idle");

      // 5a: limit 0 acts as 1
      RST_LMT = 8'h00;
      WDFAIL  = 1'b1;
      run(1, 1'b1, "lmt0_rise");
      WDFAIL = 1'b0;
      run(3, 1'b1, "lmt0_pulse");
      run(2, 1'b0, "lmt0_fall");

      // 5b: limit 1
      RST_LMT = 8'h01;
      WDFAIL  = 1'b1;
      run(1, 1'b1, "lmt1_rise");
      WDFAIL = 1'b0;
      run(3, 1'b1, "lmt1_pulse");
      run(2, 1'b0, "lmt1_fall");

      // 5c: limit changed mid-count is ignored
      RST_LMT = 8'h05;
      WDFAIL  = 1'b1;
      run(2, 1'b0, "midchg_pre");
      RST_LMT = 8'h03;
      run(2, 1'b0, "midchg_ignored");
      run(1, 1'b1, "midchg_rise5");
      WDFAIL = 1'b0;
      run(3, 1'b1, "midchg_pulse");
      run(2, 1'b0, "midchg_fall");

      // 6: async reset during FIRE
      RST_LMT = 8'h0A;
      WDFAIL  = 1'b1;
      run(9, 1'b0, "abort_pre");
      run(2, 1'b1, "abort_fire");
      #3;
      RST_N = 1'b0;
      #1;
      chk(1'b0, "abort_async_drop");
      WDFAIL = 1'b0;
      run(1, 1'b0, "abort_in_reset");
      RST_N = 1'b1;
      run(1, 1'b0, "abort_release");
      WDFAIL = 1'b1;
      run(9, 1'b0, "abort_idle_count");
      run(1, 1'b1, "abort_idle_rise");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
